// File: rtl/tm1638_display_writer.sv
// TM1638 display writer: takes a 3-decade packed BCD value and, on request,
// writes one full refresh (data command, address command + 16 display bytes,
// display-control command) over the STB/CLK/DIO bus. Write-only, keys unused.
module tm1638_display_writer #(
   parameter int CLK_DIV    = 2,
   parameter int BRIGHTNESS = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] bcd_in,
   input  logic        update,
   output logic        busy,
   output logic        done,
   output logic        tm_stb,
   output logic        tm_clk,
   output logic        tm_dio
);

   typedef enum logic [2:0] {S_IDLE, S_F1, S_GAP1, S_F2, S_GAP2, S_F3} state_t;
   typedef enum logic [1:0] {P_SETUP, P_LOW, P_HIGH, P_HOLD} phase_t;

   localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
   localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);
   localparam logic [7:0] CMD_DATA = 8'h40;
   localparam logic [7:0] CMD_ADDR = 8'hC0;
   localparam logic [7:0] CMD_CTRL = 8'h88 | 8'(BRIGHTNESS % 8);

   // Seven-segment pattern, bit0=a .. bit6=g, dp off; non-decimal nibbles show a dash.
   function automatic logic [7:0] seg(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'd0:    s = 8'h3F;
         4'd1:    s = 8'h06;
         4'd2:    s = 8'h5B;
         4'd3:    s = 8'h4F;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'h6D;
         4'd6:    s = 8'h7D;
         4'd7:    s = 8'h07;
         4'd8:    s = 8'h7F;
         4'd9:    s = 8'h6F;
         default: s = 8'h40;
      endcase
      return s;
   endfunction

   // Byte on the wire for a given frame and byte index. In F2, index 0 is
   // the address command, so display address N is byte index N+1.
   function automatic logic [7:0] frame_byte(input state_t st, input logic [4:0] idx,
                                             input logic [11:0] bcd);
      logic [7:0] b;
      case (st)
         S_F1: b = CMD_DATA;
         S_F3: b = CMD_CTRL;
         S_F2: begin
            case (idx)
               5'd0:    b = CMD_ADDR;
               5'd11:   b = seg(bcd[11:8]);
               5'd13:   b = seg(bcd[7:4]);
               5'd15:   b = seg(bcd[3:0]);
               default: b = 8'h00;
            endcase
         end
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic [8:0]  div_q, div_d;
   logic [2:0]  bit_q, bit_d;
   logic [4:0]  byte_q, byte_d;
   logic [11:0] bcd_q, bcd_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        stb_q, stb_d;
   logic        tclk_q, tclk_d;
   logic        dio_q, dio_d;

   logic        in_frame_s;
   logic [4:0]  last_byte_s;
   logic [7:0]  cur_byte_s;

   // Next-state sequencing of frames, bit phases and counters; pins derive from the next state.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      div_d       = div_q;
      bit_d       = bit_q;
      byte_d      = byte_q;
      bcd_d       = bcd_q;
      done_d      = 1'b0;
      last_byte_s = (state_q == S_F2) ? 5'd16 : 5'd0;

      case (state_q)
         S_IDLE: begin
            if (update) begin
               state_d = S_F1;
               phase_d = P_SETUP;
               div_d   = 9'd0;
               bit_d   = 3'd0;
               byte_d  = 5'd0;
               bcd_d   = bcd_in;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_F1, S_F2, S_F3: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + 9'd1;
            end else begin
               div_d = 9'd0;
               case (phase_q)
                  P_SETUP: phase_d = P_LOW;
                  P_LOW:   phase_d = P_HIGH;
                  P_HIGH: begin
                     if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (byte_q == last_byte_s) begin
                           phase_d = P_HOLD;
                        end else begin
                           byte_d  = byte_q + 5'd1;
                           phase_d = P_LOW;
                        end
                     end else begin
                        bit_d   = bit_q + 3'd1;
                        phase_d = P_LOW;
                     end
                  end
                  P_HOLD: begin
                     phase_d = P_SETUP;
                     byte_d  = 5'd0;
                     case (state_q)
                        S_F1:    state_d = S_GAP1;
                        S_F2:    state_d = S_GAP2;
                        default: begin
                           state_d = S_IDLE;
                           done_d  = 1'b1;
                        end
                     endcase
                  end
                  default: phase_d = P_SETUP;
               endcase
            end
         end
         S_GAP1, S_GAP2: begin
            if (div_q == GAP_LAST) begin
               div_d   = 9'd0;
               phase_d = P_SETUP;
               state_d = (state_q == S_GAP1) ? S_F2 : S_F3;
            end else begin
               div_d = div_q + 9'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_frame_s = (state_d == S_F1) || (state_d == S_F2) || (state_d == S_F3);
      cur_byte_s = frame_byte(state_d, byte_d, bcd_d);
      busy_d     = (state_d != S_IDLE);
      stb_d      = ~in_frame_s;
      tclk_d     = ~(in_frame_s && (phase_d == P_LOW));
      if (!in_frame_s) begin
         dio_d = 1'b1;
      end else if (phase_d == P_LOW) begin
         dio_d = cur_byte_s[bit_d];
      end else begin
         dio_d = dio_q;
      end
   end

   // State and pin registers; reset aborts any sequence and parks the bus idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= P_SETUP;
         div_q   <= 9'd0;
         bit_q   <= 3'd0;
         byte_q  <= 5'd0;
         bcd_q   <= 12'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         stb_q   <= 1'b1;
         tclk_q  <= 1'b1;
         dio_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         bcd_q   <= bcd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         stb_q   <= stb_d;
         tclk_q  <= tclk_d;
         dio_q   <= dio_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign tm_stb = stb_q;
   assign tm_clk = tclk_q;
   assign tm_dio = dio_q;

endmodule

// File: tb/tb_tm1638_display_writer.sv
// Testbench for tm1638_display_writer: two instances (D=2/bright 7, D=1/bright 0),
// a bus decoder per instance and a byte scoreboard fed when updates are issued.
module tb_tm1638_display_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        upd0, upd1;
   logic [11:0] bcd0, bcd1;
   logic        busy0, done0, stb0, tclk0, dio0;
   logic        busy1, done1, stb1, tclk1, dio1;

   tm1638_display_writer #(.CLK_DIV(2), .BRIGHTNESS(7)) dut0 (
      .clk(clk), .rst(rst), .bcd_in(bcd0), .update(upd0), .busy(busy0), .done(done0),
      .tm_stb(stb0), .tm_clk(tclk0), .tm_dio(dio0));

   tm1638_display_writer #(.CLK_DIV(1), .BRIGHTNESS(0)) dut1 (
      .clk(clk), .rst(rst), .bcd_in(bcd1), .update(upd1), .busy(busy1), .done(done1),
      .tm_stb(stb1), .tm_clk(tclk1), .tm_dio(dio1));

   logic [1:0] stb_w, clk_w, dio_w, busy_w, done_w;
   assign stb_w  = {stb1, stb0};
   assign clk_w  = {tclk1, tclk0};
   assign dio_w  = {dio1, dio0};
   assign busy_w = {busy1, busy0};
   assign done_w = {done1, done0};

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [7:0] exp_b0[$], exp_b1[$];
   int         exp_l0[$], exp_l1[$];
   int         done_cnt [2];
   int         nbytes   [2];
   bit         skip     [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] seg_m(input logic [3:0] n);
      logic [7:0] t [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
      if (n > 4'd9) return 8'h40;
      return t[n];
   endfunction

   task automatic push_b(input int idx, input logic [7:0] b);
      if (idx == 0) exp_b0.push_back(b);
      else          exp_b1.push_back(b);
   endtask

   task automatic push_l(input int idx, input int l);
      if (idx == 0) exp_l0.push_back(l);
      else          exp_l1.push_back(l);
   endtask

   task automatic push_seq(input int idx, input logic [11:0] bcd, input logic [7:0] f3);
      logic [7:0] b;
      push_b(idx, 8'h40); push_l(idx, 1);
      push_b(idx, 8'hC0);
      for (int a = 0; a < 16; a++) begin
         b = 8'h00;
         if (a == 10) b = seg_m(bcd[11:8]);
         if (a == 12) b = seg_m(bcd[7:4]);
         if (a == 14) b = seg_m(bcd[3:0]);
         push_b(idx, b);
      end
      push_l(idx, 17);
      push_b(idx, f3); push_l(idx, 1);
   endtask

   function automatic logic [31:0] pop_b(input int idx);
      if (idx == 0) return (exp_b0.size() == 0) ? 32'hFFFF_FFFF : {24'd0, exp_b0.pop_front()};
      return (exp_b1.size() == 0) ? 32'hFFFF_FFFF : {24'd0, exp_b1.pop_front()};
   endfunction

   function automatic logic [31:0] pop_l(input int idx);
      if (idx == 0) return (exp_l0.size() == 0) ? 32'hFFFF_FFFF : exp_l0.pop_front();
      return (exp_l1.size() == 0) ? 32'hFFFF_FFFF : exp_l1.pop_front();
   endfunction

   // Bus decoder and protocol checker for one instance, sampling on the falling edge.
   task automatic monitor(input int idx);
      logic ps = 1'b1, pc = 1'b1, pd = 1'b1, pb = 1'b0;
      logic s, c, d, b, dn;
      logic [7:0] sh = 8'd0;
      int nbits = 0, nb = 0, run = 0, gap = 0, setup = 0;
      bit gbusy = 1'b0, setup_pend = 1'b0;
      int dd;
      dd = (idx == 0) ? 2 : 1;
      forever begin
         @(negedge clk);
         s = stb_w[idx]; c = clk_w[idx]; d = dio_w[idx]; b = busy_w[idx]; dn = done_w[idx];
         if (!ps && !s && pc && c) chk($sformatf("dio_stable_%0d", idx), {31'd0, d}, {31'd0, pd});
         if (s) begin
            chk($sformatf("clk_idle_hi_%0d", idx), {31'd0, c}, 32'd1);
            chk($sformatf("dio_idle_hi_%0d", idx), {31'd0, d}, 32'd1);
         end
         if (s && !ps) begin
            if (skip[idx]) skip[idx] = 1'b0;
            else chk($sformatf("frame_len_%0d", idx), nb, pop_l(idx));
            gap = 0;
            gbusy = b;
         end
         if (!s && ps) begin
            if (gbusy) chk($sformatf("gap_len_%0d", idx), gap, 2 * dd);
            nb = 0; nbits = 0; nbytes[idx] = 0; setup = 0; setup_pend = 1'b1;
         end
         if (s) gap++;
         if (!s && setup_pend) begin
            if (c) setup++;
            else begin
               chk($sformatf("setup_len_%0d", idx), setup, dd);
               setup_pend = 1'b0;
            end
         end
         if (!s && !pc && c) begin
            sh = {d, sh[7:1]};
            nbits++;
            if (nbits == 8) begin
               chk($sformatf("byte_%0d", idx), {24'd0, sh}, pop_b(idx));
               nb++;
               nbytes[idx] = nb;
               nbits = 0;
            end
         end
         if (b) run++;
         if (dn) begin
            chk($sformatf("done_at_busy_fall_%0d", idx), {30'd0, pb, b}, 32'd2);
            chk($sformatf("busy_len_%0d", idx), run, 314 * dd);
            done_cnt[idx]++;
         end
         if (!b) run = 0;
         ps = s; pc = c; pd = d; pb = b;
      end
   endtask

   task automatic wait_done(input int idx, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (done_w[idx] === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, {31'd0, seen}, 32'd1);
   endtask

   task automatic wait_bytes(input int n, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (nbytes[0] >= n) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, {31'd0, seen}, 32'd1);
   endtask

   // Directed sequence of scenarios.
   initial begin
      rst = 1'b1; upd0 = 1'b0; upd1 = 1'b0; bcd0 = 12'h000; bcd1 = 12'h000;
      done_cnt = '{0, 0}; nbytes = '{0, 0}; skip = '{1'b0, 1'b0};
      repeat (3) @(negedge clk);
      chk("reset_pins0", {27'd0, stb0, tclk0, dio0, busy0, done0}, 32'h1C);
      chk("reset_pins1", {27'd0, stb1, tclk1, dio1, busy1, done1}, 32'h1C);
      rst = 1'b0;
      fork
         monitor(0);
         monitor(1);
      join_none

      // Basic refresh showing 1,2,3.
      @(negedge clk);
      bcd0 = 12'h123; upd0 = 1'b1; push_seq(0, 12'h123, 8'h8F);
      @(negedge clk);
      upd0 = 1'b0;
      chk("accept_busy", {31'd0, busy0}, 32'd1);
      wait_done(0, "t1_done");
      repeat (5) @(negedge clk);
      chk("t1_done_cnt", done_cnt[0], 32'd1);

      // Digits 9, dash, 0 on both brightness settings.
      bcd0 = 12'h9A0; upd0 = 1'b1; push_seq(0, 12'h9A0, 8'h8F);
      bcd1 = 12'h9A0; upd1 = 1'b1; push_seq(1, 12'h9A0, 8'h88);
      @(negedge clk);
      upd0 = 1'b0; upd1 = 1'b0;
      wait_done(1, "t2_done1");
      wait_done(0, "t2_done0");
      repeat (5) @(negedge clk);
      chk("t2_done_cnt0", done_cnt[0], 32'd2);
      chk("t2_done_cnt1", done_cnt[1], 32'd1);

      // Re-request and input change mid-F2 are ignored.
      bcd0 = 12'h123; upd0 = 1'b1; push_seq(0, 12'h123, 8'h8F);
      @(negedge clk);
      upd0 = 1'b0;
      wait_bytes(3, "t3_reach_f2");
      bcd0 = 12'h555; upd0 = 1'b1;
      @(negedge clk);
      upd0 = 1'b0;
      wait_done(0, "t3_done");
      repeat (50) @(negedge clk);
      chk("t3_no_second", {31'd0, busy0}, 32'd0);
      chk("t3_done_cnt", done_cnt[0], 32'd3);
      chk("t3_queue_empty", exp_b0.size(), 32'd0);

      // Reset in the middle of F2 byte 5, then a clean sequence.
      bcd0 = 12'h456; upd0 = 1'b1; push_seq(0, 12'h456, 8'h8F);
      @(negedge clk);
      upd0 = 1'b0;
      wait_bytes(5, "t4_reach_byte5");
      repeat (3) @(negedge clk);
      rst = 1'b1; skip[0] = 1'b1;
      @(negedge clk);
      chk("t4_abort_pins", {27'd0, stb0, tclk0, dio0, busy0, done0}, 32'h1C);
      rst = 1'b0;
      exp_b0.delete(); exp_l0.delete();
      repeat (5) @(negedge clk);
      chk("t4_no_done", done_cnt[0], 32'd3);
      bcd0 = 12'h789; upd0 = 1'b1; push_seq(0, 12'h789, 8'h8F);
      @(negedge clk);
      upd0 = 1'b0;
      wait_done(0, "t4_done");
      repeat (5) @(negedge clk);
      chk("t4_done_cnt", done_cnt[0], 32'd4);

      // Update held high: back-to-back sequences each capturing the current input.
      bcd0 = 12'h111; upd0 = 1'b1; push_seq(0, 12'h111, 8'h8F);
      @(negedge clk);
      bcd0 = 12'h222; push_seq(0, 12'h222, 8'h8F);
      wait_done(0, "t5_done1");
      chk("t5_busy_low_at_done", {31'd0, busy0}, 32'd0);
      @(negedge clk);
      chk("t5_restart1", {31'd0, busy0}, 32'd1);
      bcd0 = 12'h333; push_seq(0, 12'h333, 8'h8F);
      wait_done(0, "t5_done2");
      @(negedge clk);
      chk("t5_restart2", {31'd0, busy0}, 32'd1);
      upd0 = 1'b0;
      wait_done(0, "t5_done3");
      repeat (20) @(negedge clk);
      chk("t5_idle", {31'd0, busy0}, 32'd0);
      chk("t5_done_cnt", done_cnt[0], 32'd7);

      chk("final_bytes0", exp_b0.size(), 32'd0);
      chk("final_lens0", exp_l0.size(), 32'd0);
      chk("final_bytes1", exp_b1.size(), 32'd0);
      chk("final_lens1", exp_l1.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
